// File: rtl/game_timer_ctrl.sv
// -----------------------------------------------------------------------------
// game_timer_ctrl
//
// Round-clock controller. It gates the 1 ms tick into the external one-second
// timer and requests a clear of that timer on start, restart and stop. It
// counts one_sec_tick pulses down from ROUND_SECONDS and pulses time_up on
// expiry. Near the end of a round it raises warn and drives a blink phase for
// the HUD.
//
// Optional feature macro: GAME_TIMER_BCD_EN
//   defined   : sec_tens/sec_ones carry the registered BCD of seconds_left,
//               saturating at 99.
//   undefined : sec_tens/sec_ones are tied to 0.
//
// Ports
//   clk             system clock
//   rst             asynchronous reset, active low
//   one_milli_tick  1-cycle pulse every 1 ms
//   one_sec_tick    1-cycle pulse from the one-second timer
//   start           start or restart the round
//   pause           toggle pause
//   stop            abort to idle
//   ms_tick_gated   registered one_milli_tick while RUNNING
//   timer_clr       registered clear request for the one-second timer
//   seconds_left    remaining seconds
//   running/paused  state flags
//   time_up         1-cycle pulse on expiry
//   warn            end-of-round warning window
//   blink           HUD blink phase
//   sec_tens/ones   BCD digits of seconds_left
// -----------------------------------------------------------------------------
module game_timer_ctrl #(
   parameter int ROUND_SECONDS = 60,
   parameter int WARN_SECONDS  = 10,
   parameter int BLINK_MS      = 250,
   parameter int SEC_W         = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             one_milli_tick,
   input  logic             one_sec_tick,
   input  logic             start,
   input  logic             pause,
   input  logic             stop,
   output logic             ms_tick_gated,
   output logic             timer_clr,
   output logic [SEC_W-1:0] seconds_left,
   output logic             running,
   output logic             paused,
   output logic             time_up,
   output logic             warn,
   output logic             blink,
   output logic [3:0]       sec_tens,
   output logic [3:0]       sec_ones
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUNNING = 2'd1,
      S_PAUSED  = 2'd2,
      S_EXPIRED = 2'd3
   } state_e;

   localparam int               CNT_W    = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
   localparam logic [SEC_W-1:0] RELOAD   = SEC_W'(ROUND_SECONDS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_MS - 1);

   state_e             state_q, state_d;
   logic [SEC_W-1:0]   seconds_left_q, seconds_left_d;
   logic               timer_clr_q, timer_clr_d;
   logic               ms_tick_gated_q, ms_tick_gated_d;
   logic               running_q, running_d;
   logic               paused_q, paused_d;
   logic               time_up_q, time_up_d;
   logic               warn_q, warn_d;
   logic               blink_q, blink_d;
   logic [CNT_W-1:0]   blink_cnt_q, blink_cnt_d;
   logic               restart;

   // Round state machine and countdown.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch; blocking '=' is correct here.
      state_d        = state_q;
      seconds_left_d = seconds_left_q;
      timer_clr_d    = timer_clr_q;
      time_up_d      = 1'b0;
      restart        = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            timer_clr_d    = 1'b1;
            seconds_left_d = RELOAD;
            if (start) begin
               state_d     = S_RUNNING;
               timer_clr_d = 1'b0;
            end
         end

         S_RUNNING: begin
            timer_clr_d = 1'b0;
            if (stop) begin
               state_d        = S_IDLE;
               seconds_left_d = RELOAD;
               timer_clr_d    = 1'b1;
            end else if (start) begin
               seconds_left_d = RELOAD;
               timer_clr_d    = 1'b1;
               restart        = 1'b1;
            end else begin
               if (one_sec_tick) begin
                  if (seconds_left_q == SEC_W'(1)) begin
                     state_d        = S_EXPIRED;
                     seconds_left_d = '0;
                     time_up_d      = 1'b1;
                     timer_clr_d    = 1'b1;
                  end else if (seconds_left_q != '0) begin
                     seconds_left_d = seconds_left_q - 1'b1;
                  end
               end
               // Pause coinciding with a tick keeps the decrement; expiry wins.
               if (pause && (state_d == S_RUNNING)) begin
                  state_d = S_PAUSED;
               end
            end
         end

         S_PAUSED: begin
            // Timer is not cleared so the sub-second phase survives the pause.
            timer_clr_d = 1'b0;
            if (stop) begin
               state_d        = S_IDLE;
               seconds_left_d = RELOAD;
               timer_clr_d    = 1'b1;
            end else if (start) begin
               state_d        = S_RUNNING;
               seconds_left_d = RELOAD;
               timer_clr_d    = 1'b1;
               restart        = 1'b1;
            end else if (pause) begin
               state_d = S_RUNNING;
            end
         end

         S_EXPIRED: begin
            timer_clr_d    = 1'b1;
            seconds_left_d = '0;
            if (stop) begin
               state_d        = S_IDLE;
               seconds_left_d = RELOAD;
            end else if (start) begin
               state_d        = S_RUNNING;
               seconds_left_d = RELOAD;
               timer_clr_d    = 1'b0;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Gated tick, status flags, warning window and blink phase.
   always_comb begin
      ms_tick_gated_d = one_milli_tick && (state_q == S_RUNNING);
      running_d       = (state_d == S_RUNNING);
      paused_d        = (state_d == S_PAUSED);
      warn_d          = (running_d || paused_d) && (seconds_left_d != '0) &&
                        (int'(seconds_left_d) <= WARN_SECONDS);
      blink_d         = blink_q;
      blink_cnt_d     = blink_cnt_q;

      if (!warn_d) begin
         blink_d     = 1'b0;
         blink_cnt_d = '0;
      end else if (!warn_q || restart) begin
         blink_d     = 1'b1;
         blink_cnt_d = '0;
      end else if (ms_tick_gated_d) begin
         if (blink_cnt_q == CNT_LAST) begin
            blink_cnt_d = '0;
            blink_d     = !blink_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking '<=' so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= S_IDLE;
         seconds_left_q  <= RELOAD;
         timer_clr_q     <= 1'b1;
         ms_tick_gated_q <= 1'b0;
         running_q       <= 1'b0;
         paused_q        <= 1'b0;
         time_up_q       <= 1'b0;
         warn_q          <= 1'b0;
         blink_q         <= 1'b0;
         blink_cnt_q     <= '0;
      end else begin
         state_q         <= state_d;
         seconds_left_q  <= seconds_left_d;
         timer_clr_q     <= timer_clr_d;
         ms_tick_gated_q <= ms_tick_gated_d;
         running_q       <= running_d;
         paused_q        <= paused_d;
         time_up_q       <= time_up_d;
         warn_q          <= warn_d;
         blink_q         <= blink_d;
         blink_cnt_q     <= blink_cnt_d;
      end
   end

   assign ms_tick_gated = ms_tick_gated_q;
   assign timer_clr     = timer_clr_q;
   assign seconds_left  = seconds_left_q;
   assign running       = running_q;
   assign paused        = paused_q;
   assign time_up       = time_up_q;
   assign warn          = warn_q;
   assign blink         = blink_q;

`ifdef GAME_TIMER_BCD_EN
   function automatic logic [7:0] to_bcd(input logic [SEC_W-1:0] v);
      int n;
      n = int'(v);
      if (n > 99) return 8'h99;
      return {4'(n / 10), 4'(n % 10)};
   endfunction

   localparam logic [7:0] BCD_RST = to_bcd(RELOAD);

   logic [7:0] bcd_q, bcd_d;

   always_comb bcd_d = to_bcd(seconds_left_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) bcd_q <= BCD_RST;
      else      bcd_q <= bcd_d;
   end

   assign sec_tens = bcd_q[7:4];
   assign sec_ones = bcd_q[3:0];
`else
   assign sec_tens = 4'd0;
   assign sec_ones = 4'd0;
`endif

endmodule

// File: tb/tb_game_timer_ctrl.sv
module tb_game_timer_ctrl;

   localparam int ROUND = 5;
   localparam int WARN  = 2;
   localparam int BLINK = 4;
   localparam int SEC_W = 7;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             one_milli_tick = 1'b0;
   logic             one_sec_tick = 1'b0;
   logic             start = 1'b0;
   logic             pause = 1'b0;
   logic             stop = 1'b0;
   logic             ms_tick_gated;
   logic             timer_clr;
   logic [SEC_W-1:0] seconds_left;
   logic             running;
   logic             paused;
   logic             time_up;
   logic             warn;
   logic             blink;
   logic [3:0]       sec_tens;
   logic [3:0]       sec_ones;

   always #5 clk = ~clk;

   game_timer_ctrl #(
      .ROUND_SECONDS(ROUND),
      .WARN_SECONDS (WARN),
      .BLINK_MS     (BLINK),
      .SEC_W        (SEC_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .one_milli_tick(one_milli_tick),
      .one_sec_tick  (one_sec_tick),
      .start         (start),
      .pause         (pause),
      .stop          (stop),
      .ms_tick_gated (ms_tick_gated),
      .timer_clr     (timer_clr),
      .seconds_left  (seconds_left),
      .running       (running),
      .paused        (paused),
      .time_up       (time_up),
      .warn          (warn),
      .blink         (blink),
      .sec_tens      (sec_tens),
      .sec_ones      (sec_ones)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: a round is "active" (running or on hold), "done"
   // (expired) or neither (idle). Blink phase is derived from the number of
   // gated ms ticks seen since the warning window opened.
   bit m_active, m_held, m_done, m_warn;
   int m_secs, m_ms_since;
   bit e_gated, e_clr, e_time_up;
   int e_tens, e_ones;

   function automatic int bcd_tens(input int s);
`ifdef GAME_TIMER_BCD_EN
      return (s > 99) ? 9 : s / 10;
`else
      return 0;
`endif
   endfunction

   function automatic int bcd_ones(input int s);
`ifdef GAME_TIMER_BCD_EN
      return (s > 99) ? 9 : s % 10;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      m_active   = 0;
      m_held     = 0;
      m_done     = 0;
      m_warn     = 0;
      m_secs     = ROUND;
      m_ms_since = 0;
      e_gated    = 0;
      e_clr      = 1;
      e_time_up  = 0;
      e_tens     = bcd_tens(ROUND);
      e_ones     = bcd_ones(ROUND);
   endtask

   task automatic model_step(input bit ms, input bit sec, input bit st,
                             input bit pa, input bit sp);
      bit was_running;
      bit restart;
      bit new_warn;
      was_running = m_active && !m_held;
      restart     = 0;
      e_tens      = bcd_tens(m_secs);
      e_ones      = bcd_ones(m_secs);
      e_gated     = ms && was_running;
      e_time_up   = 0;

      if (sp && (m_active || m_done)) begin
         m_active = 0; m_held = 0; m_done = 0; m_secs = ROUND;
      end else if (st) begin
         restart  = m_active;
         m_active = 1; m_held = 0; m_done = 0; m_secs = ROUND;
      end else if (m_active) begin
         if (!m_held && sec) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) begin
               m_active  = 0;
               m_done    = 1;
               e_time_up = 1;
            end
         end
         if (pa && m_active) m_held = !m_held;
      end

      e_clr    = !m_active || restart;
      new_warn = m_active && (m_secs >= 1) && (m_secs <= WARN);
      if (!new_warn || !m_warn || restart) m_ms_since = 0;
      else if (e_gated) m_ms_since++;
      m_warn = new_warn;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string step);
      bit e_blink;
      e_blink = m_warn && (((m_ms_since / BLINK) % 2) == 0);
      check({step, ".ms_tick_gated"}, 32'(ms_tick_gated), 32'(e_gated));
      check({step, ".timer_clr"},     32'(timer_clr),     32'(e_clr));
      check({step, ".seconds_left"},  32'(seconds_left),  32'(m_secs));
      check({step, ".running"},       32'(running),       32'(m_active && !m_held));
      check({step, ".paused"},        32'(paused),        32'(m_active && m_held));
      check({step, ".time_up"},       32'(time_up),       32'(e_time_up));
      check({step, ".warn"},          32'(warn),          32'(m_warn));
      check({step, ".blink"},         32'(blink),         32'(e_blink));
      check({step, ".sec_tens"},      32'(sec_tens),      32'(e_tens));
      check({step, ".sec_ones"},      32'(sec_ones),      32'(e_ones));
   endtask

   // Called at a falling edge: drive inputs, let one rising edge happen,
   // advance the model, then compare at the next falling edge.
   task automatic cycle(input string step, input bit ms, input bit sec,
                        input bit st, input bit pa, input bit sp);
      one_milli_tick = ms;
      one_sec_tick   = sec;
      start          = st;
      pause          = pa;
      stop           = sp;
      @(posedge clk);
      model_step(ms, sec, st, pa, sp);
      @(negedge clk);
      one_milli_tick = 0;
      one_sec_tick   = 0;
      start          = 0;
      pause          = 0;
      stop           = 0;
      check_all(step);
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      check("reset.timer_clr_const", 32'(timer_clr), 32'd1);
      rst = 1'b1;
      cycle("idle", 0, 0, 0, 0, 0);
      cycle("idle_stop", 0, 0, 0, 0, 1);
      cycle("idle_sec", 0, 1, 0, 0, 0);

      // 1: start, gated tick latency
      cycle("start", 0, 0, 1, 0, 0);
      check("tp1.timer_clr", 32'(timer_clr), 32'd0);
      check("tp1.running", 32'(running), 32'd1);
      check("tp1.seconds", 32'(seconds_left), 32'd5);
      cycle("ms_in", 1, 0, 0, 0, 0);
      check("tp1.gated_n1", 32'(ms_tick_gated), 32'd1);
      cycle("ms_gap", 0, 0, 0, 0, 0);
      check("tp1.gated_off", 32'(ms_tick_gated), 32'd0);

      // 2: full countdown to expiry
      for (int i = 4; i >= 0; i--) begin
         cycle("countdown", 0, 1, 0, 0, 0);
         check("tp2.seconds", 32'(seconds_left), 32'(i));
      end
      check("tp2.time_up", 32'(time_up), 32'd1);
      check("tp2.timer_clr", 32'(timer_clr), 32'd1);
      cycle("after_expiry", 0, 1, 0, 0, 0);
      check("tp2.time_up_once", 32'(time_up), 32'd0);
      check("tp2.no_underflow", 32'(seconds_left), 32'd0);
      cycle("expired_pause", 0, 0, 0, 1, 0);

      // 3: pause holds count and sub-second phase
      cycle("restart_from_exp", 0, 0, 1, 0, 0);
      cycle("to4", 0, 1, 0, 0, 0);
      cycle("to3", 0, 1, 0, 0, 0);
      cycle("pause", 0, 0, 0, 1, 0);
      check("tp3.paused", 32'(paused), 32'd1);
      for (int i = 0; i < 12; i++) cycle("paused_ticks", 1, (i % 5) == 0, 0, 0, 0);
      check("tp3.gated", 32'(ms_tick_gated), 32'd0);
      check("tp3.seconds", 32'(seconds_left), 32'd3);
      check("tp3.timer_clr", 32'(timer_clr), 32'd0);
      cycle("resume", 0, 0, 0, 1, 0);
      cycle("to2", 0, 1, 0, 0, 0);
      check("tp3.resumed", 32'(seconds_left), 32'd2);

      // 4: warning blink
      check("tp4.warn", 32'(warn), 32'd1);
      check("tp4.blink_rise", 32'(blink), 32'd1);
      repeat (4) cycle("blink_a", 1, 0, 0, 0, 0);
      check("tp4.blink_low", 32'(blink), 32'd0);
      repeat (4) cycle("blink_b", 1, 0, 0, 0, 0);
      check("tp4.blink_high", 32'(blink), 32'd1);
      cycle("blink_pause", 0, 0, 0, 1, 0);
      repeat (8) cycle("blink_frozen", 1, 0, 0, 0, 0);
      check("tp4.blink_frozen", 32'(blink), 32'd1);
      cycle("blink_resume", 0, 0, 0, 1, 0);
      repeat (3) cycle("blink_c", 1, 0, 0, 0, 0);

      // 5: same-cycle events
      cycle("restart", 0, 0, 1, 0, 0);
      cycle("to4b", 0, 1, 0, 0, 0);
      cycle("to3b", 0, 1, 0, 0, 0);
      cycle("stop_start", 0, 0, 1, 0, 1);
      check("tp5.stop_wins", 32'(running), 32'd0);
      check("tp5.stop_reload", 32'(seconds_left), 32'd5);
      cycle("start2", 0, 0, 1, 0, 0);
      cycle("to4c", 0, 1, 0, 0, 0);
      cycle("to3c", 0, 1, 0, 0, 0);
      cycle("start_sec", 0, 1, 1, 0, 0);
      check("tp5.start_reload", 32'(seconds_left), 32'd5);
      check("tp5.clr_pulse", 32'(timer_clr), 32'd1);
      cycle("clr_drop", 0, 0, 0, 0, 0);
      check("tp5.clr_once", 32'(timer_clr), 32'd0);
      cycle("to4d", 0, 1, 0, 0, 0);
      cycle("pause_sec", 0, 1, 0, 1, 0);
      check("tp5.pause_sec", 32'(seconds_left), 32'd3);
      check("tp5.pause_state", 32'(paused), 32'd1);
      cycle("unpause", 0, 0, 0, 1, 0);

      // Randomised traffic against the model
      for (int i = 0; i < 600; i++) begin
         cycle("random",
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 4) == 0,
               $urandom_range(0, 29) == 0,
               $urandom_range(0, 14) == 0,
               $urandom_range(0, 49) == 0);
      end

      // 6: asynchronous reset mid-round
      cycle("pre_rst_start", 0, 0, 1, 0, 0);
      cycle("pre_rst4", 0, 1, 0, 0, 0);
      cycle("pre_rst3", 0, 1, 0, 0, 0);
      cycle("pre_rst2", 0, 1, 0, 0, 0);
      check("tp6.at2", 32'(seconds_left), 32'd2);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      check("tp6.seconds", 32'(seconds_left), 32'd5);
      check("tp6.running", 32'(running), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      cycle("post_rst_start", 0, 0, 1, 0, 0);
      cycle("post_rst_dec", 0, 1, 0, 0, 0);
      cycle("post_rst_bcd", 0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
